// File: rtl/iso_tu_scheduler_pkg.sv
// Shared definitions for the isochronous transfer-unit scheduler.
//   - slot-type encodings driven on sched_stream_state
//   - FSM state enum
//   - default TU size / accumulator width and the integer cap
//   - slot_type(): slot classification for a position within a TU
package iso_tu_scheduler_pkg;

  localparam int TU_SIZE_DFLT = 64;
  localparam int FRAC_W_DFLT  = 10;
  localparam int VLD_INT_MAX  = 60;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_BLANK  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SLOT_FILL = 2'b00,
    SLOT_DATA = 2'b01,
    SLOT_FS   = 2'b10,
    SLOT_FE   = 2'b11
  } slot_t;

  // FE owns the last slot; DATA fills [0, n); FS marks the first non-data slot.
  function automatic slot_t slot_type(input logic [5:0] pos,
                                      input logic [6:0] n,
                                      input logic [5:0] last);
    if (pos == last)
      return SLOT_FE;
    else if ({1'b0, pos} < n)
      return SLOT_DATA;
    else if ({1'b0, pos} == n)
      return SLOT_FS;
    else
      return SLOT_FILL;
  endfunction

endpackage

// File: rtl/iso_tu_scheduler_if.sv
// Control/status bundle of the TU scheduler.
//   master : iso_start, cfg_load, cfg_vld_int, cfg_vld_frac, blank_req,
//            fifo_empty (driven); scheduler outputs (observed)
//   slave  : the scheduler itself
interface iso_tu_scheduler_if #(
  parameter int FRAC_W = 10
);
  logic              iso_start;
  logic              cfg_load;
  logic [5:0]        cfg_vld_int;
  logic [FRAC_W-1:0] cfg_vld_frac;
  logic              blank_req;
  logic              fifo_empty;
  logic              sched_stream_en;
  logic [1:0]        sched_stream_state;
  logic              sched_blank_en;
  logic              fifo_rd;
  logic [5:0]        tu_pos;
  logic              underflow;

  modport master (
    output iso_start, cfg_load, cfg_vld_int, cfg_vld_frac, blank_req, fifo_empty,
    input  sched_stream_en, sched_stream_state, sched_blank_en, fifo_rd, tu_pos, underflow
  );

  modport slave (
    input  iso_start, cfg_load, cfg_vld_int, cfg_vld_frac, blank_req, fifo_empty,
    output sched_stream_en, sched_stream_state, sched_blank_en, fifo_rd, tu_pos, underflow
  );
endinterface

// File: rtl/iso_frac_acc.sv
// Fractional valid-symbol accumulator.
//   clk, rst : clock, async active-high reset (clears the accumulator)
//   frac     : fractional increment, units of 1/2^FRAC_W
//   step     : advance the accumulator by frac on this edge
//   carry    : the current step overflows one whole symbol
module iso_frac_acc #(
  parameter int FRAC_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FRAC_W-1:0] frac,
  input  logic              step,
  output logic              carry
);
  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W:0]   sum;

  assign sum   = {1'b0, acc_q} + {1'b0, frac};
  assign carry = sum[FRAC_W];

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values; = here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc_q <= '0;
    else if (step)
      acc_q <= sum[FRAC_W-1:0];   // modulo 2^FRAC_W; overflow leaves as carry
  end
endmodule

// File: rtl/iso_tu_scheduler.sv
// Transfer-unit slot scheduler for an isochronous link stream.
//   clk, rst : link-symbol clock, async active-high reset
//   bus      : iso_tu_scheduler_if.slave (controls in, slot outputs out)
// All outputs are registered together so tu_pos always names the slot whose
// type is on sched_stream_state.
module iso_tu_scheduler
  import iso_tu_scheduler_pkg::*;
#(
  parameter int TU_SIZE = TU_SIZE_DFLT,
  parameter int FRAC_W  = FRAC_W_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  iso_tu_scheduler_if.slave bus
);
  localparam logic [5:0] LAST_POS = 6'(TU_SIZE - 1);
  localparam logic [5:0] INT_CAP  = 6'(VLD_INT_MAX);

  state_t            state_q, state_d;
  logic [5:0]        pos_q, pos_d;
  logic [6:0]        n_q, n_d, n_base;
  logic [5:0]        vld_int_sh;
  logic [FRAC_W-1:0] vld_frac_sh;
  logic              tu_end, enter_tu, carry;

  logic       stream_en_q, stream_en_d;
  logic [1:0] slot_q, slot_d;
  logic       blank_en_q, blank_en_d;
  logic       fifo_rd_q, fifo_rd_d;
  logic       underflow_q, underflow_d;

  // Shadows are only consumed at TU entry, so a load lands at the next
  // boundary and the last load within a TU wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_int_sh  <= '0;
      vld_frac_sh <= '0;
    end else if (bus.cfg_load) begin
      vld_int_sh  <= bus.cfg_vld_int;
      vld_frac_sh <= bus.cfg_vld_frac;
    end
  end

  // Steps only when an ACTIVE TU starts, so BLANK TUs freeze it.
  iso_frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
    .clk   (clk),
    .rst   (rst),
    .frac  (vld_frac_sh),
    .step  (enter_tu),
    .carry (carry)
  );

  // Next state, slot position and per-TU data count.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    tu_end  = (state_q != ST_IDLE) && (pos_q == LAST_POS);
    unique case (state_q)
      ST_IDLE:             if (bus.iso_start) state_d = ST_ACTIVE;
      ST_ACTIVE, ST_BLANK: if (tu_end) begin
                             if (!bus.iso_start)    state_d = ST_IDLE;
                             else if (bus.blank_req) state_d = ST_BLANK;
                             else                    state_d = ST_ACTIVE;
                           end
      default:             state_d = ST_IDLE;
    endcase

    enter_tu = (state_d == ST_ACTIVE) && ((state_q == ST_IDLE) || tu_end);

    if (state_d == ST_IDLE || state_q == ST_IDLE || tu_end)
      pos_d = '0;
    else
      pos_d = 6'(pos_q + 6'd1);

    n_base = (vld_int_sh > INT_CAP) ? {1'b0, INT_CAP} : {1'b0, vld_int_sh};
    n_d    = enter_tu ? 7'(n_base + {6'd0, carry}) : n_q;
  end

  // Output values for the slot about to be driven.
  always_comb begin
    stream_en_d = 1'b0;
    slot_d      = SLOT_FILL;
    blank_en_d  = 1'b0;
    fifo_rd_d   = 1'b0;
    unique case (state_d)
      ST_ACTIVE: begin
        stream_en_d = 1'b1;
        slot_d      = slot_type(pos_d, n_d, LAST_POS);
        fifo_rd_d   = (slot_type(pos_d, n_d, LAST_POS) == SLOT_DATA);
      end
      ST_BLANK:  blank_en_d = 1'b1;
      default:   ;
    endcase

    // Sticky across IDLE; only a fresh start clears it.
    underflow_d = underflow_q | (fifo_rd_q & bus.fifo_empty);
    if (state_q == ST_IDLE && state_d == ST_ACTIVE)
      underflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      n_q         <= '0;
      stream_en_q <= 1'b0;
      slot_q      <= SLOT_FILL;
      blank_en_q  <= 1'b0;
      fifo_rd_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      n_q         <= n_d;
      stream_en_q <= stream_en_d;
      slot_q      <= slot_d;
      blank_en_q  <= blank_en_d;
      fifo_rd_q   <= fifo_rd_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.sched_stream_en    = stream_en_q;
  assign bus.sched_stream_state = slot_q;
  assign bus.sched_blank_en     = blank_en_q;
  assign bus.fifo_rd            = fifo_rd_q;
  assign bus.tu_pos             = pos_q;
  assign bus.underflow          = underflow_q;

endmodule

// File: tb/tb_iso_tu_scheduler.sv
// Directed bench for iso_tu_scheduler: reset, integer/fractional TU fill,
// mid-TU config loads, blanking, stop, underflow and mid-TU reset.
module tb_iso_tu_scheduler;
  localparam int TU = 64;

  localparam int K_NONE   = 0;
  localparam int K_BLANK1 = 1;  // raise blank_req
  localparam int K_BLANK0 = 2;  // drop blank_req
  localparam int K_STOP   = 3;  // drop iso_start (and raise blank_req)
  localparam int K_EMPTY  = 4;  // fifo_empty during one DATA slot
  localparam int K_RESET  = 5;  // assert rst mid-TU
  localparam int K_LOAD2  = 6;  // two cfg loads within the TU

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic exp_uf;

  iso_tu_scheduler_if #(.FRAC_W(10)) bus ();

  iso_tu_scheduler #(.TU_SIZE(64), .FRAC_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_slot(input int p, input int n);
    if (p == TU - 1) return 2'b11;
    else if (p < n)  return 2'b01;
    else if (p == n) return 2'b10;
    else             return 2'b00;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_pos"},   32'(bus.tu_pos), 0);
    check({tag, "_en"},    32'(bus.sched_stream_en), 0);
    check({tag, "_state"}, 32'(bus.sched_stream_state), 0);
    check({tag, "_blank"}, 32'(bus.sched_blank_en), 0);
    check({tag, "_rd"},    32'(bus.fifo_rd), 0);
    check({tag, "_uf"},    32'(bus.underflow), 32'(exp_uf));
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_zero(tag);
    end
  endtask

  task automatic load_cfg(input logic [5:0] vi, input logic [9:0] vf);
    @(negedge clk);
    bus.cfg_load     = 1'b1;
    bus.cfg_vld_int  = vi;
    bus.cfg_vld_frac = vf;
    @(negedge clk);
    bus.cfg_load     = 1'b0;
  endtask

  // Checks one full TU slot by slot; optional stimulus event inside it.
  task automatic run_tu(input string tag, input bit blank, input int n_exp,
                        input int kind, input int ev_slot);
    int rd_cnt;
    rd_cnt = 0;
    for (int p = 0; p < TU; p++) begin
      @(negedge clk);
      if (kind == K_EMPTY && p == ev_slot + 1) exp_uf = 1'b1;
      check({tag, "_pos"}, 32'(bus.tu_pos), 32'(p));
      if (blank) begin
        check({tag, "_en"},    32'(bus.sched_stream_en), 0);
        check({tag, "_blank"}, 32'(bus.sched_blank_en), 1);
        check({tag, "_state"}, 32'(bus.sched_stream_state), 0);
        check({tag, "_rd"},    32'(bus.fifo_rd), 0);
      end else begin
        check({tag, "_en"},    32'(bus.sched_stream_en), 1);
        check({tag, "_blank"}, 32'(bus.sched_blank_en), 0);
        check({tag, "_state"}, 32'(bus.sched_stream_state), 32'(exp_slot(p, n_exp)));
        check({tag, "_rd"},    32'(bus.fifo_rd), (p < n_exp) ? 1 : 0);
      end
      check({tag, "_uf"}, 32'(bus.underflow), 32'(exp_uf));
      if (bus.fifo_rd === 1'b1) rd_cnt++;

      if (p == ev_slot) begin
        case (kind)
          K_BLANK1: bus.blank_req = 1'b1;
          K_BLANK0: bus.blank_req = 1'b0;
          K_STOP: begin
            bus.iso_start = 1'b0;
            bus.blank_req = 1'b1;
          end
          K_EMPTY:  bus.fifo_empty = 1'b1;
          K_RESET: begin
            rst           = 1'b1;
            bus.iso_start = 1'b0;
            exp_uf        = 1'b0;
            #1;
            check_zero({tag, "_rst_now"});
            return;
          end
          K_LOAD2: begin
            bus.cfg_load     = 1'b1;
            bus.cfg_vld_int  = 6'd5;
            bus.cfg_vld_frac = 10'd0;
          end
          default: ;
        endcase
      end
      if (kind == K_EMPTY && p == ev_slot + 1) bus.fifo_empty = 1'b0;
      if (kind == K_LOAD2) begin
        if (p == ev_slot + 1 || p == ev_slot + 21) bus.cfg_load = 1'b0;
        if (p == ev_slot + 20) begin
          bus.cfg_load     = 1'b1;
          bus.cfg_vld_int  = 6'd10;
          bus.cfg_vld_frac = 10'd512;
        end
      end
    end
    check({tag, "_rd_count"}, 32'(rd_cnt), blank ? 0 : 32'(n_exp));
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    exp_uf           = 1'b0;
    rst              = 1'b1;
    bus.iso_start    = 1'b0;
    bus.cfg_load     = 1'b0;
    bus.cfg_vld_int  = '0;
    bus.cfg_vld_frac = '0;
    bus.blank_req    = 1'b0;
    bus.fifo_empty   = 1'b0;

    // Reset state, then release and stay idle without iso_start.
    idle_check("in_reset", 2);
    rst = 1'b0;
    idle_check("idle", 3);

    // int=10, frac=0: loading a config alone does not start scheduling.
    load_cfg(6'd10, 10'd0);
    idle_check("idle_cfg", 2);
    bus.iso_start = 1'b1;
    run_tu("tu_int10_a", 1'b0, 10, K_NONE, -1);
    // Two loads in this TU (int=5 at slot 20, int=10/frac=512 at slot 40);
    // the later one governs the next TUs.
    run_tu("tu_load2", 1'b0, 10, K_LOAD2, 20);

    // frac=512: acc 0->512 (10), ->0 carry (11), 10, 11.
    run_tu("tu_frac_1", 1'b0, 10, K_NONE, -1);
    run_tu("tu_frac_2", 1'b0, 11, K_NONE, -1);
    run_tu("tu_frac_3", 1'b0, 10, K_NONE, -1);
    run_tu("tu_frac_4", 1'b0, 11, K_NONE, -1);

    // Blank requested at slot 30: this TU completes (acc -> 512).
    run_tu("tu_pre_blank", 1'b0, 10, K_BLANK1, 30);
    // Blank TU; request dropped mid-TU at slot 20.
    run_tu("tu_blank", 1'b1, 0, K_BLANK0, 20);
    // Frozen acc 512 + 512 carries.
    run_tu("tu_post_blank", 1'b0, 11, K_NONE, -1);

    // iso_start dropped at slot 5 with blank_req high: finish TU, then IDLE.
    run_tu("tu_stop", 1'b0, 10, K_STOP, 5);
    idle_check("idle_stop", 4);
    bus.blank_req = 1'b0;

    // Underflow: frac=0 so acc (512) never carries.
    load_cfg(6'd10, 10'd0);
    bus.iso_start = 1'b1;
    run_tu("tu_uf", 1'b0, 10, K_EMPTY, 3);
    run_tu("tu_uf_hold", 1'b0, 10, K_STOP, 5);
    idle_check("idle_uf", 3);
    bus.blank_req = 1'b0;
    bus.iso_start = 1'b1;
    exp_uf        = 1'b0;
    run_tu("tu_uf_clr", 1'b0, 10, K_NONE, -1);

    // Reset mid-TU at slot 40, no restart until iso_start returns.
    run_tu("tu_rst", 1'b0, 10, K_RESET, 40);
    @(negedge clk);
    check_zero("rst_held");
    rst = 1'b0;
    idle_check("idle_after_rst", 4);

    // Shadows were cleared: n=0 -> FS at 0, FE at 63, no reads.
    bus.iso_start = 1'b1;
    run_tu("tu_n0", 1'b0, 0, K_NONE, -1);
    bus.iso_start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
